// File: rtl/mem_line_arbiter_if.sv
// Bus bundle between the two L1 refill requesters, the line arbiter and the memory/MMU bridge.
// The slave modport is the arbiter's view; the master modport drives the caches and memory side.
interface mem_line_arbiter_if;
    logic [31:0]  ic_addr_i;
    logic         ic_rd_i;
    logic [255:0] ic_data_o;
    logic         ic_ack_o;
    logic         ic_fault_o;
    logic [31:0]  dc_addr_i;
    logic         dc_rd_i;
    logic         dc_we_i;
    logic [255:0] dc_data_i;
    logic [255:0] dc_data_o;
    logic         dc_ack_o;
    logic         dc_fault_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_rd_o;
    logic         mem_we_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_fault_i;
    logic         busy_o;

    modport slave (
        input  ic_addr_i, ic_rd_i, dc_addr_i, dc_rd_i, dc_we_i, dc_data_i,
        input  mem_data_i, mem_ack_i, mem_fault_i,
        output ic_data_o, ic_ack_o, ic_fault_o, dc_data_o, dc_ack_o, dc_fault_o,
        output mem_addr_o, mem_data_o, mem_rd_o, mem_we_o, busy_o
    );

    modport master (
        output ic_addr_i, ic_rd_i, dc_addr_i, dc_rd_i, dc_we_i, dc_data_i,
        output mem_data_i, mem_ack_i, mem_fault_i,
        input  ic_data_o, ic_ack_o, ic_fault_o, dc_data_o, dc_ack_o, dc_fault_o,
        input  mem_addr_o, mem_data_o, mem_rd_o, mem_we_o, busy_o
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Shares the 256-bit line-fill memory port between IC refill and DC refill/writeback.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN (synthesises a faulting ack after TIMEOUT cycles).
//
// state  | meaning
// IDLE   | no grant; arbitrate on the next edge
// GNT_IC | IC read owns the memory port until mem_ack_i (or watchdog)
// GNT_DC | DC read/write owns the memory port until mem_ack_i (or watchdog)
module mem_line_arbiter #(
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_line_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_e;

    state_e        state_q, state_d;
    logic          last_dc_q, last_dc_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [255:0]  mem_data_q, mem_data_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_we_q, mem_we_d;
    logic          ic_req, dc_req, pick_dc, to_hit, done, gnt_ic, gnt_dc, fault_val;

    assign ic_req  = bus.ic_rd_i;
    assign dc_req  = bus.dc_rd_i | bus.dc_we_i;
    assign pick_dc = dc_req & (~ic_req | ~RR | ~last_dc_q);

    assign gnt_ic    = (state_q == GNT_IC);
    assign gnt_dc    = (state_q == GNT_DC);
    assign done      = bus.mem_ack_i | to_hit;
    // A real memory ack wins over the watchdog and carries its own fault value.
    assign fault_val = bus.mem_ack_i ? bus.mem_fault_i : to_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_q, wd_d;

    assign to_hit = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (state_q != IDLE && !done)
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    // TIMEOUT only matters to the watchdog; tying it in here keeps the parameter referenced.
    assign to_hit = 1'b0 & (TIMEOUT == 0);
`endif

    always_comb begin
        state_d    = state_q;
        last_dc_d  = last_dc_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        case (state_q)
            IDLE: begin
                if (pick_dc) begin
                    state_d    = GNT_DC;
                    last_dc_d  = 1'b1;
                    mem_addr_d = bus.dc_addr_i;
                    mem_we_d   = bus.dc_we_i;
                    mem_rd_d   = ~bus.dc_we_i;
                    if (bus.dc_we_i)
                        mem_data_d = bus.dc_data_i;
                end else if (ic_req) begin
                    state_d    = GNT_IC;
                    last_dc_d  = 1'b0;
                    mem_addr_d = bus.ic_addr_i;
                    mem_rd_d   = 1'b1;
                    mem_we_d   = 1'b0;
                end
            end
            GNT_IC, GNT_DC: begin
                if (done) begin
                    state_d    = IDLE;
                    mem_addr_d = '0;
                    mem_rd_d   = 1'b0;
                    mem_we_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_dc_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dc_q  <= last_dc_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;
    assign bus.mem_rd_o   = mem_rd_q;
    assign bus.mem_we_o   = mem_we_q;
    assign bus.busy_o     = (state_q != IDLE);

    assign bus.ic_ack_o   = gnt_ic & done;
    assign bus.dc_ack_o   = gnt_dc & done;
    assign bus.ic_fault_o = gnt_ic & fault_val;
    assign bus.dc_fault_o = gnt_dc & fault_val;
    assign bus.ic_data_o  = bus.mem_data_i;
    assign bus.dc_data_o  = bus.mem_data_i;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: one round-robin instance and one fixed-priority instance.
// Defining MEM_ARB_TIMEOUT_EN also exercises the watchdog with TIMEOUT=8.
module tb_mem_line_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_line_arbiter_if bus_a ();
    mem_line_arbiter_if bus_b ();

    mem_line_arbiter #(.RR(1'b1), .TIMEOUT(TMO)) u_rr (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mem_line_arbiter #(.RR(1'b0), .TIMEOUT(TMO)) u_fp (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int n_chk = 0;
    int n_err = 0;

    logic         s_busy, s_rd, s_we, s_ic_ack, s_dc_ack, s_ic_f, s_dc_f;
    logic [31:0]  s_addr;
    logic [255:0] s_wdata, s_ic_d, s_dc_d;

    localparam logic [255:0] PAT1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] PAT2 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] WB_D = {16{16'hBEEF}};

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic samp(input bit fp);
        if (fp) begin
            s_busy = bus_b.busy_o;     s_rd = bus_b.mem_rd_o;       s_we = bus_b.mem_we_o;
            s_ic_ack = bus_b.ic_ack_o; s_dc_ack = bus_b.dc_ack_o;
            s_ic_f = bus_b.ic_fault_o; s_dc_f = bus_b.dc_fault_o;
            s_addr = bus_b.mem_addr_o; s_wdata = bus_b.mem_data_o;
            s_ic_d = bus_b.ic_data_o;  s_dc_d = bus_b.dc_data_o;
        end else begin
            s_busy = bus_a.busy_o;     s_rd = bus_a.mem_rd_o;       s_we = bus_a.mem_we_o;
            s_ic_ack = bus_a.ic_ack_o; s_dc_ack = bus_a.dc_ack_o;
            s_ic_f = bus_a.ic_fault_o; s_dc_f = bus_a.dc_fault_o;
            s_addr = bus_a.mem_addr_o; s_wdata = bus_a.mem_data_o;
            s_ic_d = bus_a.ic_data_o;  s_dc_d = bus_a.dc_data_o;
        end
    endtask

    task automatic drive_mem(input bit fp, input logic ack, input logic fault, input logic [255:0] d);
        if (fp) begin
            bus_b.mem_ack_i = ack; bus_b.mem_fault_i = fault; bus_b.mem_data_i = d;
        end else begin
            bus_a.mem_ack_i = ack; bus_a.mem_fault_i = fault; bus_a.mem_data_i = d;
        end
    endtask

    // Entered at the negedge of the first grant cycle; returns at the negedge of the IDLE gap.
    task automatic txn(input bit fp, input bit exp_dc, input bit exp_we, input logic [31:0] exp_addr,
                       input int lat, input logic fault, input logic [255:0] rdata);
        samp(fp);
        check("grant_busy", s_busy, 1'b1);
        check("grant_rd", s_rd, !exp_we);
        check("grant_we", s_we, exp_we);
        check("grant_addr", s_addr, exp_addr);
        if (exp_we) check("grant_wdata", s_wdata, WB_D);
        repeat (lat) @(posedge clk);
        #1 drive_mem(fp, 1'b1, fault, rdata);
        @(negedge clk);
        samp(fp);
        check("ack_ic", s_ic_ack, !exp_dc);
        check("ack_dc", s_dc_ack, exp_dc);
        check("fault_ic", s_ic_f, !exp_dc & fault);
        check("fault_dc", s_dc_f, exp_dc & fault);
        check("ack_data", exp_dc ? s_dc_d : s_ic_d, rdata);
        check("hold_addr", s_addr, exp_addr);
        check("hold_strobe", s_rd | s_we, 1'b1);
        @(posedge clk);
        #1 drive_mem(fp, 1'b0, 1'b0, '0);
        @(negedge clk);
        samp(fp);
        check("gap_busy", s_busy, 1'b0);
        check("gap_strobe", s_rd | s_we, 1'b0);
        check("gap_addr", s_addr, 32'h0);
    endtask

    initial begin
        bus_a.ic_addr_i = '0; bus_a.ic_rd_i = 0; bus_a.dc_addr_i = '0; bus_a.dc_rd_i = 0;
        bus_a.dc_we_i = 0; bus_a.dc_data_i = '0;
        bus_b.ic_addr_i = '0; bus_b.ic_rd_i = 0; bus_b.dc_addr_i = '0; bus_b.dc_rd_i = 0;
        bus_b.dc_we_i = 0; bus_b.dc_data_i = '0;
        drive_mem(1'b0, 1'b0, 1'b0, '0);
        drive_mem(1'b1, 1'b0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        samp(1'b0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_rd", s_rd, 1'b0);
        check("rst_we", s_we, 1'b0);
        check("rst_addr", s_addr, 32'h0);
        check("rst_wdata", s_wdata, 256'h0);

        // Ack while IDLE must not be forwarded.
        drive_mem(1'b0, 1'b1, 1'b1, PAT1);
        #1 samp(1'b0);
        check("idle_ack_ic", s_ic_ack, 1'b0);
        check("idle_ack_dc", s_dc_ack, 1'b0);
        check("idle_fault_dc", s_dc_f, 1'b0);
        drive_mem(1'b0, 1'b0, 1'b0, '0);

        // Single IC read.
        bus_a.ic_addr_i = 32'h0000_1040; bus_a.ic_rd_i = 1'b1;
        @(negedge clk);
        txn(1'b0, 1'b0, 1'b0, 32'h0000_1040, 3, 1'b0, PAT1);
        bus_a.ic_rd_i = 1'b0;
        @(negedge clk);
        samp(1'b0);
        check("ic_done_idle", s_busy, 1'b0);

        // Round-robin with both held: DC, IC, DC, IC.
        bus_a.ic_addr_i = 32'h0000_2000; bus_a.ic_rd_i = 1'b1;
        bus_a.dc_addr_i = 32'h0000_3040; bus_a.dc_we_i = 1'b1; bus_a.dc_data_i = WB_D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) txn(1'b0, 1'b1, 1'b1, 32'h0000_3040, 1, 1'b0, PAT2);
            else            txn(1'b0, 1'b0, 1'b0, 32'h0000_2000, 2, 1'b0, PAT1);
        end
        bus_a.ic_rd_i = 1'b0; bus_a.dc_we_i = 1'b0;

        // DC read with page fault.
        bus_a.dc_addr_i = 32'h0000_5080; bus_a.dc_rd_i = 1'b1;
        @(negedge clk);
        txn(1'b0, 1'b1, 1'b0, 32'h0000_5080, 1, 1'b1, PAT2);
        bus_a.dc_rd_i = 1'b0;

        // Fixed priority: DC keeps winning until its write drops.
        bus_b.ic_addr_i = 32'h0000_6000; bus_b.ic_rd_i = 1'b1;
        bus_b.dc_addr_i = 32'h0000_7040; bus_b.dc_we_i = 1'b1; bus_b.dc_data_i = WB_D;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            txn(1'b1, 1'b1, 1'b1, 32'h0000_7040, 1, 1'b0, PAT1);
        end
        bus_b.dc_we_i = 1'b0;
        @(negedge clk);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_6000, 1, 1'b0, PAT2);
        bus_b.ic_rd_i = 1'b0;

        // Reset two cycles into an IC grant.
        bus_a.ic_addr_i = 32'h0000_8000; bus_a.ic_rd_i = 1'b1;
        @(negedge clk);
        samp(1'b0);
        check("pre_rst_rd", s_rd, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; bus_a.ic_rd_i = 1'b0;
        drive_mem(1'b0, 1'b1, 1'b0, PAT1);
        @(negedge clk);
        samp(1'b0);
        check("midrst_rd", s_rd, 1'b0);
        check("midrst_busy", s_busy, 1'b0);
        check("midrst_addr", s_addr, 32'h0);
        check("midrst_late_ack", s_ic_ack, 1'b0);
        @(posedge clk);
        #1 drive_mem(1'b0, 1'b0, 1'b0, '0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog acks with fault on the 8th strobe cycle.
        bus_a.ic_addr_i = 32'h0000_9000; bus_a.ic_rd_i = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 7; c++) begin
            samp(1'b0);
            check("wd_wait_ack", s_ic_ack, 1'b0);
            check("wd_wait_rd", s_rd, 1'b1);
            @(negedge clk);
        end
        samp(1'b0);
        check("wd_ack", s_ic_ack, 1'b1);
        check("wd_fault", s_ic_f, 1'b1);
        check("wd_dc_ack", s_dc_ack, 1'b0);
        bus_a.ic_rd_i = 1'b0;
        @(negedge clk);
        samp(1'b0);
        check("wd_rd_drop", s_rd, 1'b0);
        check("wd_idle", s_busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
